// File: rtl/mux8_rr_arbiter_if.sv
// mux8_rr_arbiter_if: handshake/bus bundle between the round-robin arbiter,
// the 8:1 word mux it steers, and the single downstream consumer.
//   req       requester -> arbiter   one request bit per mux input
//   gnt       arbiter -> requesters  one-hot grant, zero when idle
//   sel       arbiter -> mux         index of the granted input
//   mux_o     mux -> arbiter         mux output word
//   out_data  arbiter -> consumer    registered word
//   out_valid arbiter -> consumer    out_data valid
//   out_ready consumer -> arbiter    consumer accepts out_data
//   busy      arbiter -> system      arbiter not in IDLE
//   lock      requester -> arbiter   per-requester hold request (ARB_LOCK_EN only)
// Modport slave is the arbiter side, master is the environment side.
interface mux8_rr_arbiter_if #(
  parameter int DW = 32
);
  logic [7:0]    req;
  logic [7:0]    gnt;
  logic [2:0]    sel;
  logic [DW-1:0] mux_o;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
`ifdef ARB_LOCK_EN
  logic [7:0]    lock;
`endif

  modport slave (
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    input  req, mux_o, out_ready,
    output gnt, sel, out_data, out_valid, busy
  );

  modport master (
`ifdef ARB_LOCK_EN
    output lock,
`endif
    output req, mux_o, out_ready,
    input  gnt, sel, out_data, out_valid, busy
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter/sequencer for an 8:1 DW-bit word mux.
// Picks one requester (search from ptr upward, wrapping 7->0), drives the mux
// select for one settle cycle, registers the mux word and hands it downstream
// over valid/ready. Every output is a flop.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   arb  mux8_rr_arbiter_if.slave (req/gnt/sel/mux_o/out_*/busy[/lock])
// Optional feature macro ARB_LOCK_EN: adds lock[7:0]; a locked, still
// requesting owner may keep the grant for up to HOLD_MAX back-to-back
// transfers, skipping the IDLE cycle between them.
module mux8_rr_arbiter #(
  parameter int DW       = 32,
  parameter int HOLD_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mux8_rr_arbiter_if.slave      arb
);

  if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_hold_chk
    $error("mux8_rr_arbiter: HOLD_MAX must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    WAIT  = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [2:0]    sel_q, sel_d;
  logic [7:0]    gnt_q, gnt_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic [3:0]    pick;
`ifdef ARB_LOCK_EN
  logic [3:0]    cnt_q, cnt_d;
`endif

  // Returns {found, idx}. Scanning offsets high to low lets the lowest
  // offset from p (the highest priority) overwrite the result last.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] k;
    rr_pick = '0;
    for (int i = 7; i >= 0; i--) begin
      k = p + 3'(i);
      if (r[k]) rr_pick = {1'b1, k};
    end
  endfunction

  assign pick = rr_pick(arb.req, ptr_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    valid_d = valid_q;
`ifdef ARB_LOCK_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick[3]) begin
          gnt_d   = 8'b1 << pick[2:0];
          sel_d   = pick[2:0];
          state_d = GRANT;
`ifdef ARB_LOCK_EN
          cnt_d   = '0;
`endif
        end else begin
          gnt_d = '0;
        end
      end
      // Mux has had a full cycle to settle on sel; capture its word.
      GRANT: begin
        data_d  = arb.mux_o;
        valid_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (valid_q && arb.out_ready) begin
          valid_d = 1'b0;
`ifdef ARB_LOCK_EN
          // Locked owner re-enters GRANT directly; ptr stays so the owner
          // does not lose its place when the burst ends.
          if (arb.lock[sel_q] && arb.req[sel_q] && (cnt_q < 4'(HOLD_MAX - 1))) begin
            state_d = GRANT;
            cnt_d   = cnt_q + 4'd1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = sel_q + 3'd1;
            cnt_d   = '0;
          end
`else
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + 3'd1;
`endif
        end
      end
      default: begin
        // Unreachable encoding: recover to IDLE with outputs cleared.
        state_d = IDLE;
        gnt_d   = '0;
        sel_d   = '0;
        data_d  = '0;
        valid_d = 1'b0;
`ifdef ARB_LOCK_EN
        cnt_d   = '0;
`endif
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ARB_LOCK_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef ARB_LOCK_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign arb.gnt       = gnt_q;
  assign arb.sel       = sel_q;
  assign arb.out_data  = data_q;
  assign arb.out_valid = valid_q;
  assign arb.busy      = busy_q;

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the 8-to-1 32-bit word multiplexer.
- Up to 8 requesters compete for the shared mux. The block picks one requester and drives the mux select. It registers the mux output and hands the word downstream over a valid/ready handshake.
- Sits between requester sources (register-file ports, ALU result, memory data, etc.) and a single consumer.

Parameters:
- DW, 32, data width of the mux output and the registered output word.
- HOLD_MAX, 4, max consecutive transfers one requester may keep under lock (used only with ARB_LOCK_EN); range 1..15.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  8  request per requester; bit i = input xi of the mux.
- gnt  out  8  one-hot grant; all zero when idle.
- sel  out  3  select driven to the mux; equals the index of the granted requester.
- mux_o  in  DW  output word of the mux.
- out_data  out  DW  registered transferred word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  high in any state other than IDLE.
- lock  in  8  per-requester lock (present only with ARB_LOCK_EN).

Behaviour:
- Reset (async, immediate): state=IDLE, gnt=0, sel=0, out_valid=0, out_data=0, ptr=0, busy=0, burst count=0.
- Reset during GRANT or WAIT aborts the transfer. out_valid drops in the same instant and no word is delivered.
- All outputs are registered.
- ptr (3 bit) is the highest-priority index. Search order is ptr, ptr+1, ... mod 8, and index wrap 7->0 is natural 3-bit overflow.
- IDLE:
  - If req != 0, compute idx = first set bit of req in search order.
  - Next edge: gnt = 1<<idx, sel = idx, state = GRANT.
  - If req == 0, stay in IDLE with gnt = 0.
- GRANT (exactly 1 cycle): the mux settles on sel. Next edge: out_data <= mux_o, out_valid <= 1, state = WAIT.
- WAIT:
  - gnt, sel and out_data are held stable while out_ready = 0; this stall has no limit.
  - On the edge where out_valid & out_ready: out_valid <= 0, gnt <= 0, ptr <= idx+1, state = IDLE.
- Latency: req sampled at edge 0, gnt/sel at edge 1, out_valid at edge 2.
- Minimum 3 cycles per transfer: one IDLE cycle is mandatory between transfers.
- req[idx] deasserting during GRANT or WAIT is ignored; the transfer completes.
- New requests that arrive during GRANT or WAIT are considered only on return to IDLE.
- A requester that keeps req high is served again only after every other active requester has been served once (fairness).
- The sel value is only meaningful while gnt != 0. sel retains its last value in IDLE.
- busy = (state != IDLE).
- Encoding: IDLE=2'b00, GRANT=2'b01, WAIT=2'b10. The illegal state 2'b11 goes to IDLE on the next edge with outputs cleared.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - The lock[7:0] port exists.
  - On the WAIT handshake, if lock[idx] & req[idx] & (cnt < HOLD_MAX-1): go to GRANT with the same idx, cnt <= cnt+1, ptr unchanged, gnt kept asserted. The IDLE cycle is skipped, giving 2 cycles per transfer.
  - Otherwise behave as normal (ptr <= idx+1) and clear cnt.
  - cnt clears on every fresh grant from IDLE.
- Undefined:
  - No lock port and no cnt register.
  - Every transfer rotates the pointer.

Test Plan:
- Single requester: req=8'h04, mux_o=32'hDEADBEEF, out_ready=1.
  - Expect gnt=8'h04 and sel=2 at edge 1.
  - Expect out_valid=1 and out_data=32'hDEADBEEF at edge 2.
  - Expect ptr=3 and IDLE after the handshake.
- All requesting: req=8'hFF held, out_ready=1, from reset.
  - Expect grant order 0,1,2,...,7,0 at 3-cycle spacing; no index repeats before all 8 are served.
- Wrap: ptr=7 (after serving 6), req=8'h81.
  - Expect 7 granted next, then 0.
  - Then with req=8'h01 only, expect 0 granted again.
- Backpressure: grant requester 5, hold out_ready=0 for 10 cycles, change mux_o every cycle.
  - Expect out_data, gnt=8'h20 and sel=5 stable and out_valid=1 throughout.
  - Releasing out_ready completes exactly one transfer.
- Reset mid-WAIT: assert rst while out_valid=1.
  - Expect out_valid=0, gnt=0 and busy=0 immediately, without waiting for a clock edge.
  - After release, req=8'h10 is granted as if from reset (ptr=0 search order).
- ARB_LOCK_EN, HOLD_MAX=4: req=8'h03, lock=8'h01, out_ready=1.
  - Expect 4 back-to-back grants to 0 at 2-cycle spacing, then grant to 1.
  - Without the macro, expect alternation 0,1,0,1.
